uart_tx_stream: RTL and testbench

Synthesizable 8-bit UART transmitter with a valid/ready byte input, a small input FIFO and a runtime baud divisor. It is the transmit end of the serial link whose receive side is the bench's bit-sampling monitor. It drives the SoC's `ser_rx` pin from a bench or host-side stimulus path, or serves as a reusable transmit core behind a register front end. Frame format is 8N1 by default, with optional even parity.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 40 ++++
 rtl/uart_tx_stream.sv | 147 ++++++++++++++
 tb/tb_uart_tx_stream.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DIV_MIN   = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; first-word fall-through read.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + (AW+1)'(1);
      if (pop && !empty) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// 8-bit UART transmitter with valid/ready input FIFO and runtime baud divisor.
// Optional even parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_tx,
  output logic             busy
);

  uart_tx_state_t state;
  uart_tx_state_t state_next;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_clamped;
  logic [DIV_W-1:0] divcnt;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;
  logic             bit_end;
  logic             last_bit;
  logic             pop;
  logic             ser_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
`ifdef UART_TX_PARITY_EN
  logic             par_q;
`endif

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (in_valid && !fifo_full),
    .pop  (pop),
    .wdata(in_data),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign in_ready    = !fifo_full;
  assign busy        = (state != IDLE) || !fifo_empty;
  assign div_clamped = (div < DIV_W'(UART_DIV_MIN)) ? DIV_W'(UART_DIV_MIN) : div;
  assign bit_end     = (divcnt == div_q - DIV_W'(1));
  assign last_bit    = (bitcnt == 3'(UART_DATA_BITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: if (bit_end) state_next = DATA;
      DATA: begin
        if (bit_end && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_next = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ser_next = 1'b1;
    unique case (state)
      START:   ser_next = 1'b0;
      DATA:    ser_next = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  ser_next = par_q;
`endif
      default: ser_next = 1'b1;
    endcase
  end

  // Line is driven one cycle behind the state so it never sees input logic directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ser_tx <= 1'b1;
    else       ser_tx <= ser_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      divcnt <= '0;
      bitcnt <= '0;
      shreg  <= '0;
`ifdef UART_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else if (pop) begin
      shreg  <= fifo_rdata;
      div_q  <= div_clamped;
      divcnt <= '0;
      bitcnt <= '0;
`ifdef UART_TX_PARITY_EN
      par_q  <= ^fifo_rdata;
`endif
    end else if (state != IDLE) begin
      if (bit_end) begin
        divcnt <= '0;
        if (state == DATA) begin
          shreg  <= shreg >> 1;
          bitcnt <= bitcnt + 3'd1;
        end
      end else begin
        divcnt <= divcnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Randomized self-checking bench for uart_tx_stream: per-cycle frame model plus a
// bit-sampling receive monitor. Honours UART_TX_PARITY_EN like the design.
module tb_uart_tx_stream;

  localparam int DIV_W = 32;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [DIV_W-1:0] div = 104;
  logic [7:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             ser_tx;
  logic             busy;

  uart_tx_stream #(
    .FIFO_DEPTH(4),
    .DIV_W     (DIV_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .div     (div),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ser_tx  (ser_tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_total = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  int unsigned start_q[$];
  int          cur_div = 2;
  logic [7:0]  pb[8];
  int unsigned acc_cyc[8];
  logic        first_rdy[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line level t cycles after the accepting edge of a lone frame.
  function automatic logic exp_ser(input logic [7:0] b, input int eff, input int t);
    int k;
    if (t < 2) return 1'b1;
    k = (t - 2) / eff;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic mwait(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      if (ab) break;
      @(negedge clk);
      if (reset) ab = 1'b1;
    end
  endtask

  initial begin : monitor
    logic [7:0] got;
    logic       stopb;
    logic       par;
    bit         ab;
    forever begin
      @(negedge clk);
      if (!reset && ser_tx === 1'b0) begin
        start_q.push_back(cyc);
        ab  = 1'b0;
        got = '0;
        par = 1'b0;
        mwait(cur_div / 2, ab);
        for (int i = 0; i < 8; i++) begin
          mwait(cur_div, ab);
          got[i] = ser_tx;
        end
`ifdef UART_TX_PARITY_EN
        mwait(cur_div, ab);
        par = ser_tx;
`endif
        mwait(cur_div, ab);
        stopb = ser_tx;
        if (!ab) begin
          check("rx_pending", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("rx_byte", got, exp_q.pop_front());
          check("rx_stop", stopb, 1);
`ifdef UART_TX_PARITY_EN
          check("rx_parity", par, ^got);
`endif
        end
        while (reset) @(negedge clk);
      end
    end
  end

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b, input logic [DIV_W-1:0] d, input bit chg);
    int eff;
    int mis_s;
    int mis_b;
    int first0;
    eff    = (d < 2) ? 2 : int'(d);
    mis_s  = 0;
    mis_b  = 0;
    first0 = -1;
    cur_div = eff;
    @(negedge clk);
    div = d; in_data = b; in_valid = 1'b1;
    check("rdy_pre", in_ready, 1);
    @(posedge clk);
    exp_q.push_back(b);
    #1 in_valid = 1'b0; in_data = 8'($urandom);
    for (int t = 0; t < NB * eff + 4; t++) begin
      @(negedge clk);
      if (chg && t == eff * 3) div = 3;
      if (ser_tx !== exp_ser(b, eff, t)) mis_s++;
      if (busy !== (t < 1 + NB * eff)) mis_b++;
      if (first0 < 0 && ser_tx === 1'b0) first0 = t;
    end
    check("wave_ser", mis_s, 0);
    check("wave_busy", mis_b, 0);
    check("start_lat", first0, 2);
  endtask

  task automatic push_bytes(input int n, input int gap_max);
    int          waited;
    int          g;
    logic        r;
    int unsigned c;
    for (int i = 0; i < n; i++) begin
      waited = 0;
      @(negedge clk);
      in_data = pb[i]; in_valid = 1'b1;
      first_rdy[i] = in_ready;
      forever begin
        r = in_ready;
        c = cyc;
        @(posedge clk);
        if (r) break;
        waited++;
        if (waited > 20000) break;
        @(negedge clk);
      end
      if (r) begin
        acc_cyc[i] = c;
        exp_q.push_back(pb[i]);
      end else begin
        check("push_timeout", in_ready, 1);
      end
      if (gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        if (g > 0) begin
          #1 in_valid = 1'b0;
          repeat (g - 1) @(negedge clk);
        end
      end
    end
    #1 in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #20_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (3) @(negedge clk);
    check("rst_ser", ser_tx, 1);
    check("rst_rdy", in_ready, 1);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(8'h55, 104, 0);
    run_frame(8'hFF, 0, 0);
    run_frame(8'hA5, 5, 1);
`ifdef UART_TX_PARITY_EN
    run_frame(8'h07, 8, 0);
    run_frame(8'h03, 8, 0);
`endif

    // Loopback: two frames, stop bits butt directly against the next start.
    div = 106; cur_div = 106;
    start_q.delete();
    pb[0] = "O"; pb[1] = "K";
    push_bytes(2, 0);
    wait_idle(5000);
    check("lb_starts", start_q.size(), 2);
    if (start_q.size() >= 2) check("lb_gap", start_q[1] - start_q[0], NB * 106);

    // Backpressure: six bytes into a four-deep FIFO.
    div = 104; cur_div = 104;
    for (int i = 0; i < 6; i++) pb[i] = 8'(i + 1);
    push_bytes(6, 0);
    check("bp_rdy4", first_rdy[4], 1);
    check("bp_stall", first_rdy[5], 0);
    check("bp_gap", acc_cyc[5] - acc_cyc[0], NB * 104 + 2);
    wait_idle(20000);

    // Reset in the middle of a frame.
    pb[0] = 8'hA3;
    push_bytes(1, 0);
    repeat (300) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_ser", ser_tx, 1);
    check("mid_rst_rdy", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(8'h3C, 104, 0);

    for (int k = 0; k < 3; k++) run_frame(8'($urandom), DIV_W'($urandom_range(0, 7)), 1'($urandom));

    for (int bt = 0; bt < 4; bt++) begin
      int d;
      int n;
      d = $urandom_range(0, 9);
      n = $urandom_range(2, 7);
      div = DIV_W'(d);
      cur_div = (d < 2) ? 2 : d;
      for (int i = 0; i < n; i++) pb[i] = 8'($urandom);
      push_bytes(n, 3);
      wait_idle(2000);
    end

    repeat (20) @(negedge clk);
    check("rx_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
